// File: rtl/radar_scan_pkg.sv
// Shared definitions for the radar scan controller: register map, bit positions,
// FSM encoding and the distance code reported when no echo arrives.
package radar_scan_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RANGE  = 2'd1;
    localparam logic [1:0] ADDR_DWELL  = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_SINGLE_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT = 8;
    localparam int STAT_DIR_BIT  = 9;
    localparam int STAT_DONE_BIT = 10;

    localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TRIG,
        S_WAIT_MEAS,
        S_STEP
    } scan_state_t;

endpackage

// File: rtl/radar_scan_timer.sv
// 24-bit loadable down-counter; expired is high while the count sits at zero,
// so loading N-1 on state entry gives a state that lasts exactly N cycles.
module radar_scan_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [23:0] load_value,
    output logic        expired
);

    logic [23:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 24'd1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/radar_scan_ctrl.sv
// Avalon-MM radar scan sequencer: steps the servo between limits, fires the ranger,
// collects echo distance or timeout, and hands angle/distance samples to the plot logic.
module radar_scan_ctrl
    import radar_scan_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  angle_out,
    output logic        trig_out,
    input  logic        meas_valid,
    input  logic [15:0] meas_data,
    output logic        sample_valid,
    output logic [7:0]  sample_angle,
    output logic [15:0] sample_dist,
    output logic        irq
);

    localparam logic [23:0] TRIG_LOAD    = 24'(TRIG_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LOAD = 24'(TIMEOUT_CYCLES - 1);

    // Saturating angle moves; 9-bit intermediates so nothing wraps past 0 or 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] s,
                                           input logic [7:0] hi);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, s};
        return (sum > {1'b0, hi}) ? hi : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] s,
                                           input logic [7:0] lo);
        return ({1'b0, a} < ({1'b0, lo} + {1'b0, s})) ? lo : a - s;
    endfunction

    scan_state_t state, state_nxt;

    logic        ctrl_en, ctrl_single, ctrl_irq_en;
    logic [7:0]  range_min, range_max, range_step;
    logic [23:0] dwell;
    logic        dir, done;
    logic [15:0] last_dist;

    logic        wr_en, ctrl_wr, range_wr, dwell_wr, status_wr, abort;
    logic [7:0]  step_eff;
    logic [23:0] dwell_eff;
    logic        timer_load, timer_expired;
    logic [23:0] timer_value;
    logic        take_sample;
    logic [15:0] dist_sel;
    logic [7:0]  angle_nxt;
    logic        dir_nxt, sweep_done, done_nxt, irq_en_nxt;
    logic        unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
    assign range_wr  = wr_en && (address == ADDR_RANGE);
    assign dwell_wr  = wr_en && (address == ADDR_DWELL);
    assign status_wr = wr_en && (address == ADDR_STATUS);
    assign abort     = ctrl_wr && !writedata[CTRL_EN_BIT];

    assign step_eff  = (range_step == 8'd0) ? 8'd1 : range_step;
    assign dwell_eff = (dwell == 24'd0) ? 24'd1 : dwell;

    // A done being set this cycle beats a simultaneous software clear.
    assign done_nxt   = sweep_done || (done && !(status_wr && writedata[STAT_DONE_BIT]));
    assign irq_en_nxt = ctrl_wr ? writedata[CTRL_IRQ_EN_BIT] : ctrl_irq_en;

    assign unused_wdata = ^writedata[31:24];

    radar_scan_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        take_sample = 1'b0;
        dist_sel    = DIST_TIMEOUT;
        angle_nxt   = angle_out;
        dir_nxt     = dir;
        sweep_done  = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;

        case (state)
            S_IDLE: begin
                if (ctrl_en && !abort) begin
                    state_nxt = S_SETTLE;
                    angle_nxt = range_min;
                    dir_nxt   = 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer_expired) state_nxt = S_TRIG;
            end
            S_TRIG: begin
                if (timer_expired) state_nxt = S_WAIT_MEAS;
            end
            S_WAIT_MEAS: begin
                if (meas_valid) begin
                    take_sample = 1'b1;
                    dist_sel    = meas_data;
                    state_nxt   = S_STEP;
                end else if (timer_expired) begin
                    take_sample = 1'b1;
                    state_nxt   = S_STEP;
                end
            end
            S_STEP: begin
                if (range_min >= range_max) begin
                    angle_nxt  = range_min;
                    dir_nxt    = 1'b1;
                    sweep_done = 1'b1;
                end else if (dir) begin
                    if (angle_out >= range_max) begin
                        dir_nxt   = 1'b0;
                        angle_nxt = sat_sub(angle_out, step_eff, range_min);
                    end else begin
                        angle_nxt = sat_add(angle_out, step_eff, range_max);
                    end
                end else begin
                    if (angle_out <= range_min) begin
                        dir_nxt    = 1'b1;
                        angle_nxt  = sat_add(angle_out, step_eff, range_max);
                        sweep_done = 1'b1;
                    end else begin
                        angle_nxt = sat_sub(angle_out, step_eff, range_min);
                    end
                end
                if (sweep_done && ctrl_single) begin
                    state_nxt = S_IDLE;
                    angle_nxt = range_min;
                end else begin
                    state_nxt = S_SETTLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Software abort: drop the position without a sample and freeze the servo.
        if (state != S_IDLE && abort) begin
            state_nxt   = S_IDLE;
            take_sample = 1'b0;
            angle_nxt   = angle_out;
            dir_nxt     = dir;
            sweep_done  = 1'b0;
        end

        if (state_nxt != state) begin
            timer_load = 1'b1;
            case (state_nxt)
                S_SETTLE:    timer_value = dwell_eff - 24'd1;
                S_TRIG:      timer_value = TRIG_LOAD;
                S_WAIT_MEAS: timer_value = TIMEOUT_LOAD;
                default:     timer_value = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en      <= 1'b0;
            ctrl_single  <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            range_min    <= '0;
            range_max    <= '0;
            range_step   <= '0;
            dwell        <= '0;
            angle_out    <= '0;
            dir          <= 1'b0;
            done         <= 1'b0;
            irq          <= 1'b0;
            trig_out     <= 1'b0;
            sample_valid <= 1'b0;
            sample_angle <= '0;
            sample_dist  <= '0;
            last_dist    <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en     <= writedata[CTRL_EN_BIT];
                ctrl_single <= writedata[CTRL_SINGLE_BIT];
                ctrl_irq_en <= writedata[CTRL_IRQ_EN_BIT];
            end else if (sweep_done && ctrl_single) begin
                ctrl_en <= 1'b0;
            end
            if (range_wr) {range_step, range_max, range_min} <= writedata[23:0];
            if (dwell_wr) dwell <= writedata[23:0];
            angle_out    <= angle_nxt;
            dir          <= dir_nxt;
            done         <= done_nxt;
            irq          <= irq_en_nxt && done_nxt;
            trig_out     <= (state_nxt == S_TRIG);
            sample_valid <= take_sample;
            if (take_sample) begin
                sample_angle <= angle_out;
                sample_dist  <= dist_sel;
                last_dist    <= dist_sel;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:  readdata[2:0]  = {ctrl_irq_en, ctrl_single, ctrl_en};
            ADDR_RANGE: readdata[23:0] = {range_step, range_max, range_min};
            ADDR_DWELL: readdata[23:0] = dwell;
            ADDR_STATUS: begin
                readdata[7:0]          = angle_out;
                readdata[STAT_BUSY_BIT] = (state != S_IDLE);
                readdata[STAT_DIR_BIT]  = dir;
                readdata[STAT_DONE_BIT] = done;
                readdata[31:16]        = last_dist;
            end
            default: readdata = '0;
        endcase
    end

endmodule

// File: doc/radar_scan_ctrl.md
Name: radar_scan_ctrl

Overview:
Avalon-MM slave controller that sequences the radar servo and ultrasonic ranger for the NIOS II system. It steps an 8-bit servo angle between programmable limits, waits a dwell time, fires a trigger pulse, waits for a range measurement or a timeout, then emits an angle/distance sample to the VGA plot logic. NIOS configures it through four registers and takes an optional end-of-sweep interrupt. It replaces software bit-banging of a plain output PIO.

Parameters:
TRIG_CYCLES, 500, trig_out high time in clk cycles (10 us at 50 MHz).
TIMEOUT_CYCLES, 1500000, maximum WAIT_MEAS duration before declaring no echo. Must be below 2^24.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  register select
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational, zero wait states
angle_out  out  8  servo angle command
trig_out  out  1  ranger trigger
meas_valid  in  1  one-cycle pulse, meas_data is valid
meas_data  in  16  echo distance
sample_valid  out  1  one-cycle pulse to the VGA side
sample_angle  out  8  angle of the sample
sample_dist  out  16  distance of the sample; 0xFFFF means timeout
irq  out  1  level interrupt

Behaviour:
- Register writes occur when chipselect=1 and write_n=0. Unused bits read 0.
- Register 0, CTRL, read/write: bit0 enable, bit1 single (one sweep then stop), bit2 irq_en.
- Register 1, RANGE, read/write: [7:0] min, [15:8] max, [23:16] step. step=0 is treated as 1.
- Register 2, DWELL, read/write: [23:0] settle cycles. 0 is treated as 1.
- Register 3, STATUS, read: [7:0] angle, [8] busy, [9] dir (1 = up), [10] done, [31:16] last distance.
- Writing STATUS with bit10=1 clears done. A done set in the same cycle as the clear wins.
- Reset values: all registers 0; angle_out=0, trig_out=0, sample_*=0, irq=0; state IDLE.
- irq = irq_en AND done, registered, no extra latency beyond the register.
- States:
  - IDLE: busy=0. When enable=1: angle<=min, dir<=up, go to SETTLE.
  - SETTLE: count DWELL cycles, then go to TRIG.
  - TRIG: trig_out=1 for exactly TRIG_CYCLES, then go to WAIT_MEAS.
  - WAIT_MEAS: on meas_valid, latch meas_data. After TIMEOUT_CYCLES with no meas_valid, latch 0xFFFF. Then go to STEP. If meas_valid coincides with timeout expiry, the measurement wins. meas_valid in any other state is ignored.
  - STEP: one cycle. sample_valid=1 with sample_angle=angle and sample_dist=latched value; last distance updates. Then compute the next angle and go to SETTLE, or go to IDLE per single-sweep rule.
- Angle rule, up direction:
  - If angle>=max: dir<=down, angle<=max(angle-step, min).
  - Otherwise: angle<=min(angle+step, max).
  - Arithmetic is 9-bit, with no wrap.
- Angle rule, down direction:
  - If angle<=min: dir<=up, angle<=min(angle+step, max), done<=1 (full sweep complete).
  - Otherwise: angle<=max(angle-step, min).
- Single mode: when done is set in STEP, clear enable and go to IDLE. Angle holds at min.
- min>=max: angle is pinned to min, and every STEP completes a sweep.
- RANGE and DWELL writes while busy take effect at the next STEP or SETTLE entry. The current angle is not re-clamped until STEP.
- Writing enable=0 while busy:
  - Next cycle IDLE, trig_out=0.
  - No sample_valid for the aborted position.
  - angle_out holds its value.
- Writing enable=1 while already busy does not restart the sequence.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Decomposition:
- Package radar_scan_pkg: register address constants (CTRL=0, RANGE=1, DWELL=2, STATUS=3), CTRL/STATUS bit positions, state encoding, DIST_TIMEOUT=16'hFFFF.
- Sub-module radar_scan_timer: a 24-bit loadable down-counter with load and expired outputs. It is shared by SETTLE, TRIG and WAIT_MEAS (one instance, reloaded on each state entry).

Test Plan:
- Reset check: assert reset -> angle_out=0, trig_out=0, irq=0, read STATUS=0x00000000.
- Single sweep: RANGE=0x000A1E0A (min 10, max 30, step 10), DWELL=4, CTRL=0x3, meas_valid with 0x0123 three cycles after each trig fall -> sample_angle sequence 10,20,30,20,10, all with sample_dist 0x0123; STATUS done=1, busy=0; trig_out width exactly TRIG_CYCLES.
- Clamped steps: min=0, max=25, step=10, continuous mode -> angles 0,10,20,25,15,5,0,10; done sets when 0 is reached after the down leg.
- Timeout: bench overrides TIMEOUT_CYCLES=20, no meas_valid -> sample_dist=0xFFFF exactly 20 cycles after WAIT_MEAS entry. A meas_valid on cycle 20 -> its data is used instead.
- Abort: write CTRL=0 during WAIT_MEAS -> busy=0 and trig_out=0 next cycle, no sample_valid, angle_out unchanged. A late meas_valid is ignored.
- Interrupt: irq_en=1, single sweep completes -> irq=1. Write STATUS=0x400 -> irq=0 next cycle. A clear write in the same cycle as done set leaves done=1.
